// File: rtl/dataram_ctrl.sv
// Single-port data memory for the MIPS MEM stage: valid/ready requests, byte-enable writes,
// 1-cycle registered reads and a zero-fill sequencer after reset. Optional: DATARAM_PARITY_EN.
module dataram_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    input  logic [DATA_W/8-1:0]   req_be_i,
`ifdef DATARAM_PARITY_EN
    input  logic                  par_inject_i,
    output logic                  parity_err_o,
`endif
    output logic                  rsp_valid_o,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  init_done_o
);

    // state   | meaning
    // ST_INIT | zero-filling the array, one word per cycle; requests ignored
    // ST_RUN  | serving requests, ready every cycle
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

    state_t                state_q;
    logic [ADDR_W-1:0]     cnt_q;
    logic                  ready_q;
    logic                  init_done_q;
    logic                  rsp_valid_q;
    logic [DATA_W-1:0]     rsp_rdata_q;

    logic [DATA_W-1:0]     mem_q [DEPTH];

    logic                  accept;
    logic                  in_range;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [NB-1:0]         mem_be;
    logic [DATA_W-1:0]     rdata_d;

    assign accept   = req_valid_i & ready_q;
    assign in_range = {1'b0, req_addr_i} < DEPTH_X;

    // The fill sequencer and the request port share the single array write port.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = req_addr_i;
        mem_wdata = req_wdata_i;
        mem_be    = req_be_i;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_wdata = '0;
            mem_be    = '1;
        end else if (accept && req_we_i && in_range) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata_d = in_range ? mem_q[req_addr_i] : '0;

`ifdef DATARAM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] par_rd;
    logic          perr_d;
    logic          parity_err_q;
    logic          flip;

    // Injection only applies to request writes; the fill always stores clean parity.
    assign flip = (state_q == ST_RUN) & par_inject_i;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b]) begin
                    par_q[mem_addr][b] <= (^mem_wdata[8*b +: 8]) ^ flip;
                end
            end
        end
    end

    assign par_rd = in_range ? par_q[req_addr_i] : '0;

    always_comb begin
        perr_d = 1'b0;
        for (int b = 0; b < NB; b++) begin
            perr_d = perr_d | ((^rdata_d[8*b +: 8]) ^ par_rd[b]);
        end
        if (!in_range) begin
            perr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= (state_q == ST_RUN) & accept & ~req_we_i & perr_d;
        end
    end

    assign parity_err_o = parity_err_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    rsp_valid_q <= 1'b0;
                    cnt_q       <= cnt_q + ADDR_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_RUN;
                        ready_q     <= 1'b1;
                        init_done_q <= 1'b1;
                        cnt_q       <= '0;
                    end
                end
                ST_RUN: begin
                    ready_q     <= 1'b1;
                    init_done_q <= 1'b1;
                    rsp_valid_q <= accept & ~req_we_i;
                    if (accept && !req_we_i) begin
                        rsp_rdata_q <= rdata_d;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign init_done_o = init_done_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_dataram_ctrl.sv
// Scoreboard bench for dataram_ctrl: one full-depth and one DEPTH=200 instance share stimulus,
// each checked against its own array model.
module tb_dataram_ctrl;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int NB = DW / 8;
    localparam int D0 = 256;
    localparam int D1 = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [NB-1:0] req_be = '0;
    logic          par_inject = 1'b0;

    logic [1:0]    ready, rvalid, done, perr;
    logic [DW-1:0] rdata [2];

    dataram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D0)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(ready[0]), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
`ifdef DATARAM_PARITY_EN
        .par_inject_i(par_inject), .parity_err_o(perr[0]),
`endif
        .rsp_valid_o(rvalid[0]), .rsp_rdata_o(rdata[0]), .init_done_o(done[0])
    );

    dataram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D1)) u_dut_s (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(ready[1]), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
`ifdef DATARAM_PARITY_EN
        .par_inject_i(par_inject), .parity_err_o(perr[1]),
`endif
        .rsp_valid_o(rvalid[1]), .rsp_rdata_o(rdata[1]), .init_done_o(done[1])
    );

`ifndef DATARAM_PARITY_EN
    assign perr = 2'b00;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
    } exp_t;

    exp_t          exp_q0[$];
    exp_t          exp_q1[$];
    logic [DW-1:0] mdl  [2][256];
    logic [NB-1:0] bad  [2][256];
    logic [DW-1:0] last [2];
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic int depth_of(input int k);
        return (k == 0) ? D0 : D1;
    endfunction

    task automatic mon(input int k);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (rvalid[k]) begin
            if (k == 0) begin
                have = exp_q0.size() > 0;
                if (have) e = exp_q0.pop_front();
            end else begin
                have = exp_q1.size() > 0;
                if (have) e = exp_q1.pop_front();
            end
            if (!have) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp dut%0d actual=rsp_valid 1 required=no response pending", k);
            end else begin
                chk($sformatf("rdata_dut%0d", k), 32'(rdata[k]), 32'(e.data));
`ifdef DATARAM_PARITY_EN
                chk($sformatf("perr_dut%0d", k), 32'(perr[k]), 32'(e.perr));
`endif
            end
            last[k] = rdata[k];
        end else begin
            chk($sformatf("rdata_hold_dut%0d", k), 32'(rdata[k]), 32'(last[k]));
            chk($sformatf("perr_idle_dut%0d", k), 32'(perr[k]), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0);
            mon(1);
        end
    end

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [NB-1:0] be, input logic inj);
        exp_t e;
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = a;
        req_wdata  = wd;
        req_be     = be;
        par_inject = inj;
        for (int k = 0; k < 2; k++) begin
            if (we) begin
                if (int'(a) < depth_of(k)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (be[b]) begin
                            mdl[k][a][8*b +: 8] = wd[8*b +: 8];
                            bad[k][a][b] = inj;
                        end
                    end
                end
            end else begin
                e.data = (int'(a) < depth_of(k)) ? mdl[k][a] : '0;
                e.perr = (int'(a) < depth_of(k)) ? |bad[k][a] : 1'b0;
                if (k == 0) exp_q0.push_back(e);
                else exp_q1.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            req_valid  = 1'b0;
            par_inject = 1'b0;
        end
    endtask

    task automatic reset_and_init(input bit count_check);
        int n;
        int c0;
        int c1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rvalid), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_init_done", 32'(done), 32'd0);
        chk("rst_rdata0", 32'(rdata[0]), 32'd0);
        chk("rst_rdata1", 32'(rdata[1]), 32'd0);
        exp_q0.delete();
        exp_q1.delete();
        for (int k = 0; k < 2; k++) begin
            last[k] = '0;
            for (int a = 0; a < 256; a++) begin
                mdl[k][a] = '0;
                bad[k][a] = '0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        c0 = 0;
        c1 = 0;
        while (n < 400 && ready != 2'b11) begin
            @(posedge clk);
            #1;
            n++;
            if (ready[0] && c0 == 0) c0 = n;
            if (ready[1] && c1 == 0) c1 = n;
        end
        chk("init_ready_timeout", 32'(ready), 32'd3);
        chk("init_done_after_fill", 32'(done), 32'd3);
        if (count_check) begin
            chk("init_cycles_dut0", 32'(c0), 32'(D0));
            chk("init_cycles_dut1", 32'(c1), 32'(D1));
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 2; k++) last[k] = '0;
        reset_and_init(1'b1);

        for (int a = 0; a < 256; a++) issue(1'b0, AW'(a), '0, '0, 1'b0);
        idle(3);

        issue(1'b1, 8'h10, 16'hBEEF, 2'b11, 1'b0);
        issue(1'b0, 8'h10, '0, '0, 1'b0);
        issue(1'b1, 8'h10, 16'h1234, 2'b01, 1'b0);
        issue(1'b0, 8'h10, '0, '0, 1'b0);
        issue(1'b1, 8'h10, 16'hFFFF, 2'b00, 1'b0);
        issue(1'b0, 8'h10, '0, '0, 1'b0);
        idle(2);

        for (int a = 0; a < 4; a++) issue(1'b1, AW'(a), DW'($urandom), 2'b11, 1'b0);
        for (int a = 0; a < 4; a++) issue(1'b0, AW'(a), '0, '0, 1'b0);
        issue(1'b1, 8'd250, 16'hDEAD, 2'b11, 1'b0);
        issue(1'b0, 8'd250, '0, '0, 1'b0);
        issue(1'b1, 8'd199, 16'hC0DE, 2'b11, 1'b0);
        issue(1'b1, 8'd200, 16'h7777, 2'b11, 1'b0);
        issue(1'b0, 8'd199, '0, '0, 1'b0);
        issue(1'b0, 8'd200, '0, '0, 1'b0);
        idle(2);

        issue(1'b1, 8'd5, 16'h5555, 2'b11, 1'b0);
        issue(1'b0, 8'd5, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_reset_rsp_valid", 32'(rvalid), 32'd3);
        reset_and_init(1'b0);
        issue(1'b0, 8'd5, '0, '0, 1'b0);
        issue(1'b0, 8'h10, '0, '0, 1'b0);
        idle(2);

`ifdef DATARAM_PARITY_EN
        issue(1'b1, 8'h20, 16'hA5A5, 2'b10, 1'b1);
        issue(1'b0, 8'h20, '0, '0, 1'b0);
        issue(1'b1, 8'h20, 16'hA5A5, 2'b10, 1'b0);
        issue(1'b0, 8'h20, '0, '0, 1'b0);
        idle(2);
`endif

        for (int i = 0; i < 800; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                idle(1);
            end else begin
                issue(1'($urandom), a, DW'($urandom), NB'($urandom),
`ifdef DATARAM_PARITY_EN
                      1'($urandom_range(0, 7) == 0)
`else
                      1'b0
`endif
                );
            end
        end
        idle(5);
        chk("pending_dut0", 32'(exp_q0.size()), 32'd0);
        chk("pending_dut1", 32'(exp_q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
